// File: rtl/core_array_rd_collector_pkg.sv
// Core array shared definitions: array geometry and read-collector entry format.
package core_array_rd_collector_pkg;

  localparam int ARR_H_NUM     = 8;
  localparam int ARR_V_NUM     = 8;
  localparam int ARR_GBUS_DATA = 64;
  localparam int ARR_ROW_W     = $clog2(ARR_H_NUM);
  localparam int ARR_COL_W     = $clog2(ARR_V_NUM);

  localparam int RD_FIFO_DEPTH = 8;
  localparam int RD_AFULL_TH   = 2;

  // One buffered read result: source column plus the result word.
  typedef struct packed {
    logic [ARR_COL_W-1:0]     col;
    logic [ARR_GBUS_DATA-1:0] data;
  } rd_entry_t;

endpackage

// File: rtl/core_array_rd_collector_rd_row_fifo.sv
// Per-row synchronous FIFO for the read collector; count ranges 0..DEPTH.
module core_array_rd_collector_rd_row_fifo
  import core_array_rd_collector_pkg::*;
#(
  parameter int DEPTH = RD_FIFO_DEPTH,
  parameter int W     = ARR_COL_W + ARR_GBUS_DATA
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push on a full FIFO is only taken when the head leaves in the same cycle.
  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/core_array_rd_collector.sv
// Collects per-row gbus read results into row FIFOs and merges them round-robin
// into one valid/ready stream tagged with row and column of origin.
module core_array_rd_collector
  import core_array_rd_collector_pkg::*;
#(
  parameter int H_NUM      = ARR_H_NUM,
  parameter int V_NUM      = ARR_V_NUM,
  parameter int GBUS_DATA  = ARR_GBUS_DATA,
  parameter int FIFO_DEPTH = RD_FIFO_DEPTH,
  parameter int AFULL_TH   = RD_AFULL_TH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [H_NUM*GBUS_DATA-1:0] in_rdata,
  input  logic [H_NUM*V_NUM-1:0]     in_rvalid,
  output logic [GBUS_DATA-1:0]       out_data,
  output logic [$clog2(H_NUM)-1:0]   out_row,
  output logic [$clog2(V_NUM)-1:0]   out_col,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [H_NUM-1:0]           row_afull,
  output logic [H_NUM-1:0]           ovf_err,
  output logic [H_NUM-1:0]           mhot_err,
  input  logic                       err_clr
);

  localparam int RW    = $clog2(H_NUM);
  localparam int CW    = $clog2(V_NUM);
  localparam int EW    = CW + GBUS_DATA;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Index of the lowest set bit; lowest column wins when several fire at once.
  function automatic logic [CW-1:0] lsb_idx(input logic [V_NUM-1:0] v);
    lsb_idx = '0;
    for (int j = V_NUM - 1; j >= 0; j--) begin
      if (v[j]) lsb_idx = CW'(j);
    end
  endfunction

  logic [H_NUM-1:0] push, pop, push_ok, empty, full, mhot_set, ovf_set;
  logic [EW-1:0]    wdata      [H_NUM];
  logic [EW-1:0]    rdata      [H_NUM];
  logic [CNT_W-1:0] count      [H_NUM];
  logic [CNT_W-1:0] count_next [H_NUM];

  logic [RW-1:0]    grant_idx;
  logic             grant_found;
  logic             load;

  logic                 out_valid_q, out_valid_d;
  logic [GBUS_DATA-1:0] out_data_q,  out_data_d;
  logic [RW-1:0]        out_row_q,   out_row_d;
  logic [CW-1:0]        out_col_q,   out_col_d;
  logic [RW-1:0]        last_grant_q, last_grant_d;
  logic [H_NUM-1:0]     row_afull_q, row_afull_d;
  logic [H_NUM-1:0]     ovf_err_q,   ovf_err_d;
  logic [H_NUM-1:0]     mhot_err_q,  mhot_err_d;

  // Capture: any column valid pushes the row's data tagged with the winning column.
  always_comb begin
    for (int i = 0; i < H_NUM; i++) begin
      push[i]     = |in_rvalid[i*V_NUM +: V_NUM];
      mhot_set[i] = (in_rvalid[i*V_NUM +: V_NUM] &
                     (in_rvalid[i*V_NUM +: V_NUM] - V_NUM'(1))) != '0;
      wdata[i]    = {lsb_idx(in_rvalid[i*V_NUM +: V_NUM]),
                     in_rdata[i*GBUS_DATA +: GBUS_DATA]};
    end
  end

  for (genvar g = 0; g < H_NUM; g++) begin : g_row
    core_array_rd_collector_rd_row_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (wdata[g]),
      .rdata (rdata[g]),
      .empty (empty[g]),
      .full  (full[g]),
      .count (count[g])
    );
  end

  // Round-robin search over non-empty rows, starting one past the last grant.
  always_comb begin
    grant_idx   = last_grant_q;
    grant_found = 1'b0;
    for (int k = 1; k <= H_NUM; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % H_NUM;
      if (!grant_found && !empty[idx]) begin
        grant_found = 1'b1;
        grant_idx   = RW'(idx);
      end
    end
    load = (!out_valid_q || out_ready) && grant_found;
  end

  // Pops, accepted pushes, next-state occupancy and error set terms per row.
  always_comb begin
    for (int i = 0; i < H_NUM; i++) begin
      pop[i]         = load && (grant_idx == RW'(i));
      push_ok[i]     = push[i] && (!full[i] || pop[i]);
      ovf_set[i]     = push[i] && full[i] && !pop[i];
      count_next[i]  = count[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
      row_afull_d[i] = count_next[i] >= CNT_W'(FIFO_DEPTH - AFULL_TH);
    end
    // Clear wins only for bits with no new error this cycle.
    ovf_err_d  = err_clr ? ovf_set  : (ovf_err_q  | ovf_set);
    mhot_err_d = err_clr ? mhot_set : (mhot_err_q | mhot_set);
  end

  // Output register: load from the granted FIFO, hold while stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = rdata[grant_idx][GBUS_DATA-1:0];
      out_col_d    = rdata[grant_idx][EW-1:GBUS_DATA];
      out_row_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Output, arbiter and status registers; reset drops out_valid immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      last_grant_q <= '0;
      row_afull_q  <= '0;
      ovf_err_q    <= '0;
      mhot_err_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      last_grant_q <= last_grant_d;
      row_afull_q  <= row_afull_d;
      ovf_err_q    <= ovf_err_d;
      mhot_err_q   <= mhot_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign row_afull = row_afull_q;
  assign ovf_err   = ovf_err_q;
  assign mhot_err  = mhot_err_q;

endmodule

// File: tb/tb_core_array_rd_collector.sv
// Directed scoreboard bench for core_array_rd_collector (default 8x8x64 config).
module tb_core_array_rd_collector;
  import core_array_rd_collector_pkg::*;

  typedef struct packed {
    logic [2:0] row;
    rd_entry_t  e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [511:0] in_rdata = '0;
  logic [63:0]  in_rvalid = '0;
  logic [63:0]  out_data;
  logic [2:0]   out_row;
  logic [2:0]   out_col;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   row_afull;
  logic [7:0]   ovf_err;
  logic [7:0]   mhot_err;
  logic         err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  core_array_rd_collector dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_rdata  (in_rdata),
    .in_rvalid (in_rvalid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .row_afull (row_afull),
    .ovf_err   (ovf_err),
    .mhot_err  (mhot_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input int r, input logic [7:0] rv, input logic [63:0] d);
    in_rvalid[r*8 +: 8]  = rv;
    in_rdata[r*64 +: 64] = d;
  endtask

  task automatic expect_word(input int r, input int c, input logic [63:0] d);
    exp_t x;
    x.row    = 3'(r);
    x.e.col  = 3'(c);
    x.e.data = d;
    sb.push_back(x);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 60 && (sb.size() != 0 || out_valid); n++) tick();
    chk({name, "_sb_left"}, 128'(sb.size()), 128'(0));
    chk({name, "_idle"}, 128'(out_valid), 128'(0));
  endtask

  // Monitor: a word transfers on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got row %0d col %0d data %0h, expected none",
                 out_row, out_col, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_word", 128'({out_row, out_col, out_data}), 128'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'({out_row, out_col, out_data}), 128'(0));
    chk("rst_status", 128'({row_afull, ovf_err, mhot_err}), 128'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();

    // 1: single word, row 3, column 4; visible after the second edge
    out_ready = 1'b1;
    drive_row(3, 8'b0001_0000, 64'hA5);
    expect_word(3, 4, 64'hA5);
    tick();
    in_rvalid = '0;
    chk("t1_not_yet_valid", 128'(out_valid), 128'(0));
    tick();
    chk("t1_valid", 128'(out_valid), 128'(1));
    chk("t1_fields", 128'({out_row, out_col, out_data}), 128'({3'd3, 3'd4, 64'hA5}));
    drain("t1");

    // Prime last_grant = 7 so an all-row burst is served 0..7
    drive_row(7, 8'b0000_0001, 64'h700);
    expect_word(7, 0, 64'h700);
    tick();
    in_rvalid = '0;
    drain("t2_prime");

    // 2: all rows push one word in the same cycle, twice
    for (int i = 0; i < 8; i++) begin
      drive_row(i, 8'(1 << i), 64'h1000 + 64'(i));
      expect_word(i, i, 64'h1000 + 64'(i));
    end
    tick();
    in_rvalid = '0;
    drain("t2_burst_a");
    for (int i = 0; i < 8; i++) begin
      drive_row(i, 8'(1 << (7 - i)), 64'h2000 + 64'(i));
      expect_word(i, 7 - i, 64'h2000 + 64'(i));
    end
    tick();
    in_rvalid = '0;
    drain("t2_burst_b");

    // 3: park a row-1 word in the stalled output register, then fill row 0
    out_ready = 1'b0;
    drive_row(1, 8'b0000_0100, 64'h111);
    expect_word(1, 2, 64'h111);
    tick();
    in_rvalid = '0;
    tick();
    chk("t3_parked", 128'({out_valid, out_row}), 128'({1'b1, 3'd1}));
    for (int k = 0; k < 9; k++) begin
      drive_row(0, 8'(1 << (k % 8)), 64'h300 + 64'(k));
      if (k < 8) expect_word(0, k % 8, 64'h300 + 64'(k));
      tick();
      if (k == 4) chk("t3_afull_5", 128'(row_afull[0]), 128'(0));
      if (k == 5) begin
        chk("t3_afull_6", 128'(row_afull[0]), 128'(1));
        chk("t3_ovf_6", 128'(ovf_err), 128'(0));
      end
      if (k == 7) chk("t3_ovf_8", 128'(ovf_err), 128'(0));
      if (k == 8) chk("t3_ovf_9", 128'(ovf_err), 128'(8'h01));
    end
    in_rvalid = '0;
    out_ready = 1'b1;
    drain("t3");
    chk("t3_afull_after", 128'(row_afull), 128'(0));

    // 4: multi-hot row 5, then clear; then clear racing a new error on row 2
    drive_row(5, 8'b0100_0010, 64'h555);
    expect_word(5, 1, 64'h555);
    tick();
    in_rvalid = '0;
    chk("t4_mhot", 128'(mhot_err), 128'(8'h20));
    chk("t4_ovf_sticky", 128'(ovf_err), 128'(8'h01));
    drain("t4");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", 128'({mhot_err, ovf_err}), 128'(0));
    err_clr = 1'b1;
    drive_row(2, 8'b0000_0011, 64'h222);
    expect_word(2, 0, 64'h222);
    tick();
    err_clr = 1'b0;
    in_rvalid = '0;
    chk("t4_clr_vs_set", 128'(mhot_err), 128'(8'h04));
    drain("t4b");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // 5: full row 0, push and pop in the same cycle
    out_ready = 1'b0;
    drive_row(1, 8'b0000_0001, 64'h511);
    expect_word(1, 0, 64'h511);
    tick();
    in_rvalid = '0;
    tick();
    for (int k = 0; k < 8; k++) begin
      drive_row(0, 8'(1 << k), 64'h600 + 64'(k));
      expect_word(0, k, 64'h600 + 64'(k));
      tick();
    end
    in_rvalid = '0;
    chk("t5_full_afull", 128'(row_afull[0]), 128'(1));
    out_ready = 1'b1;
    drive_row(0, 8'b1000_0000, 64'h6FF);
    expect_word(0, 7, 64'h6FF);
    tick();
    in_rvalid = '0;
    out_ready = 1'b0;
    chk("t5_no_drop", 128'(ovf_err), 128'(0));
    chk("t5_head", 128'({out_row, out_data}), 128'({3'd0, 64'h600}));
    tick();
    chk("t5_still_full", 128'(row_afull[0]), 128'(1));
    out_ready = 1'b1;
    drain("t5");

    // 6: reset while the output is stalled and FIFOs hold data
    out_ready = 1'b0;
    drive_row(2, 8'b0000_0010, 64'hBAD2);
    drive_row(3, 8'b0000_0100, 64'hBAD3);
    drive_row(4, 8'b0000_1000, 64'hBAD4);
    tick();
    in_rvalid = '0;
    tick();
    chk("t6_pre_valid", 128'(out_valid), 128'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_valid", 128'(out_valid), 128'(0));
    chk("t6_async_out", 128'({out_row, out_col, out_data}), 128'(0));
    chk("t6_async_status", 128'({row_afull, ovf_err, mhot_err}), 128'(0));
    tick();
    tick();
    rstn = 1'b1;
    out_ready = 1'b1;
    repeat (20) tick();
    chk("t6_no_stale", 128'(out_valid), 128'(0));
    drive_row(6, 8'b0010_0000, 64'h666);
    expect_word(6, 5, 64'h666);
    tick();
    in_rvalid = '0;
    drain("t6_after");

    chk("final_sb_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
